// File: rtl/fib_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fib_pkg : shared constants, FSM encoding and FIFO entry layout       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fib_pkg;

    localparam int C_WIDTH = 4;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // FIFO entry is {wrap, term}; the wrap flag sits just above the term bits.
    typedef struct packed {
        logic               wrap;
        logic [C_WIDTH-1:0] term;
    } entry_t;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fib_sync_fifo : DEPTH x DATA_W synchronous FIFO with flush           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fib_sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int C_PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == (C_PTR_W+1)'(DEPTH));
    assign level     = r_level;
    assign head_data = r_mem[r_rd_ptr];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + (C_PTR_W+1)'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - (C_PTR_W+1)'(1);
            end
        end
    end

endmodule : fib_sync_fifo
`default_nettype wire

// File: rtl/fib_term_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fib_term_buffer : locks onto a Fibonacci stream, tags wraps, buffers |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fib_term_buffer
    import fib_pkg::*;
#(
    parameter int WIDTH  = C_WIDTH,
    parameter int DEPTH  = 4,
    parameter int DROP_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         term_in,
    input  logic                     resync,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_term,
    output logic                     out_wrap,
    output logic                     wrap_seen,
    output logic                     synced,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int C_ENTRY_W = WIDTH + 1;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_prev;
    logic                r_wrap_seen;
    logic [DROP_W-1:0]   r_drop_cnt;

    logic                w_push_req;
    logic                w_wrap_tag;
    logic                w_push_ok;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [C_ENTRY_W-1:0] w_head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A push request carries a term destined for the FIFO; resync kills it.
    always_comb begin
        w_state_next = r_state;
        w_push_req   = 1'b0;
        w_wrap_tag   = 1'b0;
        if (resync) begin
            w_state_next = SYNC;
        end else begin
            case (r_state)
                SYNC: begin
                    if (in_valid && term_in == WIDTH'(1)) begin
                        w_push_req   = 1'b1;
                        w_state_next = RUN;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        w_push_req = 1'b1;
                        w_wrap_tag = (term_in < r_prev);
                    end
                end
                default: w_state_next = SYNC;
            endcase
        end
    end

    assign w_pop     = !w_empty && out_ready;
    assign w_push_ok = w_push_req && (!w_full || w_pop);

    // prev and wrap_seen track every request so tags stay right across drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev      <= '0;
            r_wrap_seen <= 1'b0;
            r_drop_cnt  <= '0;
        end else if (resync) begin
            r_prev      <= '0;
            r_wrap_seen <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_push_req) begin
                r_prev <= term_in;
            end
            if (w_push_req && w_wrap_tag) begin
                r_wrap_seen <= 1'b1;
            end
            if (w_push_req && !w_push_ok && r_drop_cnt != {DROP_W{1'b1}}) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    fib_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (C_ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push_ok),
        .push_data ({w_wrap_tag, term_in}),
        .pop       (w_pop),
        .flush     (resync),
        .head_data (w_head),
        .level     (level),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign out_valid = !w_empty;
    assign out_term  = w_head[WIDTH-1:0];
    assign out_wrap  = w_head[WIDTH];
    assign wrap_seen = r_wrap_seen;
    assign synced    = (r_state == RUN);
    assign drop_cnt  = r_drop_cnt;

endmodule : fib_term_buffer
`default_nettype wire

// File: tb/tb_fib_term_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fib_term_buffer : directed vector bench for fib_term_buffer       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fib_term_buffer;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] term_in;
    logic       resync;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_term;
    logic       out_wrap;
    logic       wrap_seen;
    logic       synced;
    logic [2:0] level;
    logic [3:0] drop_cnt;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       iv;
        logic [3:0] t;
        logic       rdy;
        logic       rs;
        logic       ev;
        logic [3:0] et;
        logic       ew;
        logic       es;
        logic       esy;
        logic [2:0] el;
        logic [3:0] ed;
    } vec_t;

    vec_t vq[$];

    fib_term_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .term_in   (term_in),
        .resync    (resync),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_term  (out_term),
        .out_wrap  (out_wrap),
        .wrap_seen (wrap_seen),
        .synced    (synced),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic iv, input logic [3:0] t, input logic rdy,
                                input logic rs, input logic ev, input logic [3:0] et,
                                input logic ew, input logic es, input logic esy,
                                input logic [2:0] el, input logic [3:0] ed);
        vec_t v;
        v.iv = iv; v.t = t; v.rdy = rdy; v.rs = rs;
        v.ev = ev; v.et = et; v.ew = ew; v.es = es; v.esy = esy; v.el = el; v.ed = ed;
        return v;
    endfunction

    // Head term/wrap are only meaningful while out_valid, unless forced (reset check).
    task automatic check(input string name, input logic ev, input logic [3:0] et,
                         input logic ew, input logic es, input logic esy,
                         input logic [2:0] el, input logic [3:0] ed, input bit chk_data);
        n_vec++;
        if (out_valid !== ev || (chk_data && (out_term !== et || out_wrap !== ew)) ||
            wrap_seen !== es || synced !== esy || level !== el || drop_cnt !== ed) begin
            n_bad++;
            $display("FAIL %s: got v=%b t=%0d w=%b seen=%b sync=%b lvl=%0d drop=%0d; want v=%b t=%0d w=%b seen=%b sync=%b lvl=%0d drop=%0d",
                     name, out_valid, out_term, out_wrap, wrap_seen, synced, level, drop_cnt,
                     ev, et, ew, es, esy, el, ed);
        end
    endtask

    task automatic step(input logic iv, input logic [3:0] t, input logic rdy, input logic rs);
        in_valid  = iv;
        term_in   = t;
        out_ready = rdy;
        resync    = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        in_valid = 0; term_in = 0; out_ready = 0; resync = 0;
        reset = 1'b0;

        //                 iv t   rdy rs   v  t   w  seen sync lvl drop
        // Fibonacci stream with one wrap (5 after 13)
        vq.push_back(mk(1, 1,  1, 0,  1, 1,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 2,  1, 0,  1, 2,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 3,  1, 0,  1, 3,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 5,  1, 0,  1, 5,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 8,  1, 0,  1, 8,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 13, 1, 0,  1, 13, 0, 0, 1, 1, 0));
        vq.push_back(mk(1, 5,  1, 0,  1, 5,  1, 1, 1, 1, 0));
        vq.push_back(mk(1, 13, 1, 0,  1, 13, 0, 1, 1, 1, 0));
        vq.push_back(mk(0, 0,  1, 0,  0, 0,  0, 1, 1, 0, 0));
        vq.push_back(mk(0, 0,  1, 1,  0, 0,  0, 0, 0, 0, 0));
        // Lock-on: 7,0,9 ignored in SYNC, 1 locks
        vq.push_back(mk(1, 7,  1, 0,  0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk(1, 0,  1, 0,  0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk(1, 9,  1, 0,  0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1,  1, 0,  1, 1,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 2,  1, 0,  1, 2,  0, 0, 1, 1, 0));
        vq.push_back(mk(0, 0,  1, 0,  0, 0,  0, 0, 1, 0, 0));
        vq.push_back(mk(0, 0,  0, 1,  0, 0,  0, 0, 0, 0, 0));
        // Back-pressure: fill to 4, two drops, then push+pop while full
        vq.push_back(mk(1, 1,  0, 0,  1, 1,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 2,  0, 0,  1, 1,  0, 0, 1, 2, 0));
        vq.push_back(mk(1, 3,  0, 0,  1, 1,  0, 0, 1, 3, 0));
        vq.push_back(mk(1, 5,  0, 0,  1, 1,  0, 0, 1, 4, 0));
        vq.push_back(mk(1, 8,  0, 0,  1, 1,  0, 0, 1, 4, 1));
        vq.push_back(mk(1, 13, 0, 0,  1, 1,  0, 0, 1, 4, 2));
        vq.push_back(mk(1, 5,  1, 0,  1, 2,  0, 1, 1, 4, 2));
        vq.push_back(mk(0, 0,  1, 0,  1, 3,  0, 1, 1, 3, 2));
        vq.push_back(mk(0, 0,  1, 0,  1, 5,  0, 1, 1, 2, 2));
        vq.push_back(mk(0, 0,  1, 0,  1, 5,  1, 1, 1, 1, 2));
        // Refill to 3 with wrap_seen set, then resync and relock
        vq.push_back(mk(1, 8,  0, 0,  1, 5,  1, 1, 1, 2, 2));
        vq.push_back(mk(1, 13, 0, 0,  1, 5,  1, 1, 1, 3, 2));
        vq.push_back(mk(1, 2,  0, 1,  0, 0,  0, 0, 0, 0, 0));
        vq.push_back(mk(1, 1,  0, 0,  1, 1,  0, 0, 1, 1, 0));
        vq.push_back(mk(1, 2,  0, 0,  1, 1,  0, 0, 1, 2, 0));

        // Reset state while held
        #12;
        check("reset_hold", 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;

        foreach (vq[i]) begin
            step(vq[i].iv, vq[i].t, vq[i].rdy, vq[i].rs);
            check($sformatf("vec%0d", i), vq[i].ev, vq[i].et, vq[i].ew, vq[i].es,
                  vq[i].esy, vq[i].el, vq[i].ed, vq[i].ev);
        end

        // Asynchronous reset between edges with level=2
        in_valid = 0;
        #3;
        reset = 1'b0;
        #1;
        check("async_reset", 0, 0, 0, 0, 0, 0, 0, 1);
        #2;
        reset = 1'b1;
        step(1, 5, 1, 0);
        check("post_reset_sync", 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0);
        check("post_reset_lock", 1, 1, 0, 0, 1, 1, 0, 1);

        // Drop counter saturation at 15
        step(1, 2, 0, 0);
        step(1, 3, 0, 0);
        step(1, 5, 0, 0);
        check("refill_full", 1, 1, 0, 0, 1, 4, 0, 1);
        for (int k = 0; k < 17; k++) begin
            step(1, 8, 0, 0);
            check($sformatf("drop_sat%0d", k), 1, 1, 0, 0, 1, 4,
                  4'((k + 1 > 15) ? 15 : k + 1), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_fib_term_buffer
`default_nettype wire
